ntt_butterfly_ct_32b: RTL and testbench

//  Cooley-Tukey NTT butterfly back-end; sits directly downstream of the 32b Barrett modular multiplier.

---
 rtl/ntt_butterfly_ct_32b_pkg.sv | 13 +
 rtl/ntt_butterfly_ct_32b_mod_add_sub_32b.sv | 56 +++++
 rtl/ntt_butterfly_ct_32b.sv | 86 ++++++++
 tb/tb_ntt_butterfly_ct_32b.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_butterfly_ct_32b_pkg.sv
// Shared constants for the Cooley-Tukey NTT butterfly back-end.
//   DEFAULT_DATA_W  : operand / modulus width
//   DEFAULT_MUL_LAT : latency of the upstream Barrett multiplier (depth of the A delay line)
//   MOD_W           : width of the carry/borrow-extended intermediates
//   BFLY_LAT        : issue-to-oValid latency of the whole butterfly (delay line + output reg)
package ntt_butterfly_ct_32b_pkg;

  localparam int unsigned DEFAULT_DATA_W  = 32;
  localparam int unsigned DEFAULT_MUL_LAT = 10;
  localparam int unsigned MOD_W           = DEFAULT_DATA_W + 1;
  localparam int unsigned BFLY_LAT        = DEFAULT_MUL_LAT + 1;

endpackage

// File: rtl/ntt_butterfly_ct_32b_mod_add_sub_32b.sv
// mod_add_sub_32b: combinational modular add / subtract for the NTT butterfly.
// Optional feature macro: NTT_BUTTERFLY_DIV2_EN (halves both results mod q for inverse NTT).
// Ports:
//   iA    in  DATA_W  top operand, < iMod
//   iBW   in  DATA_W  twiddled operand B*W mod q, < iMod
//   iMod  in  DATA_W  modulus q (odd)
//   oSum  out DATA_W  (A+BW) mod q          [halved mod q when NTT_BUTTERFLY_DIV2_EN]
//   oDiff out DATA_W  (A-BW) mod q          [halved mod q when NTT_BUTTERFLY_DIV2_EN]
module mod_add_sub_32b
  import ntt_butterfly_ct_32b_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
  input  logic [DATA_W-1:0] iA,
  input  logic [DATA_W-1:0] iBW,
  input  logic [DATA_W-1:0] iMod,
  output logic [DATA_W-1:0] oSum,
  output logic [DATA_W-1:0] oDiff
);

  logic [DATA_W:0]   w_s;
  logic [DATA_W:0]   w_d;
  logic              w_geq;
  logic              w_borrow;
  logic [DATA_W-1:0] w_sum;
  logic [DATA_W-1:0] w_diff;

  // Full-width compare so a sum above 2^DATA_W (q near 2^DATA_W) still reduces correctly;
  // the subtraction itself can then wrap in DATA_W bits because the result is < q.
  assign w_s   = {1'b0, iA} + {1'b0, iBW};
  assign w_geq = (w_s >= {1'b0, iMod});
  assign w_sum = w_s[DATA_W-1:0] - (w_geq ? iMod : '0);

  // Borrow out of the extended subtraction means A < BW; adding q back wraps into range.
  assign w_d      = {1'b0, iA} - {1'b0, iBW};
  assign w_borrow = w_d[DATA_W];
  assign w_diff   = w_d[DATA_W-1:0] + (w_borrow ? iMod : '0);

`ifdef NTT_BUTTERFLY_DIV2_EN
  // x/2 mod q for odd q: even x -> x>>1, odd x -> (x+q)>>1. The odd case is split as
  // (x>>1) + (q>>1) + 1 so the sum never needs a DATA_W+1 bit carry.
  function automatic logic [DATA_W-1:0] f_half(input logic [DATA_W-1:0] x,
                                               input logic [DATA_W-1:0] q);
    logic [DATA_W-1:0] lsb;
    lsb = {{(DATA_W-1){1'b0}}, q[0]};
    return x[0] ? ((x >> 1) + (q >> 1) + lsb) : (x >> 1);
  endfunction

  assign oSum  = f_half(w_sum, iMod);
  assign oDiff = f_half(w_diff, iMod);
`else
  assign oSum  = w_sum;
  assign oDiff = w_diff;
`endif

endmodule

// File: rtl/ntt_butterfly_ct_32b.sv
// ntt_butterfly_ct_32b: Cooley-Tukey NTT butterfly back-end placed after the Barrett multiplier.
// Delays A (and its valid) by MUL_LAT cycles so it meets B*W mod q, then registers
// (A+BW) mod q and (A-BW) mod q. Stall (iEn) and flush (iClr) match the multiplier so the
// two pipelines stay in lockstep. Latency from issue to oValid is MUL_LAT+1 edges.
// Optional feature macro: NTT_BUTTERFLY_DIV2_EN (results halved mod q, latency unchanged).
// Ports:
//   iClk   in  1       clock
//   iRstN  in  1       asynchronous active-low reset
//   iEn    in  1       advance; 0 holds every register
//   iClr   in  1       synchronous flush, wins over iEn
//   iValid in  1       A issued this cycle
//   iA     in  DATA_W  butterfly top operand
//   iBW    in  DATA_W  multiplier output, aligned with delay-line stage MUL_LAT-1
//   iMod   in  DATA_W  modulus q (odd, quasi-static)
//   oValid out 1       oSum/oDiff valid
//   oSum   out DATA_W  (A+BW) mod q
//   oDiff  out DATA_W  (A-BW) mod q
module ntt_butterfly_ct_32b
  import ntt_butterfly_ct_32b_pkg::*;
#(
  parameter int unsigned DATA_W  = DEFAULT_DATA_W,
  parameter int unsigned MUL_LAT = DEFAULT_MUL_LAT
) (
  input  logic              iClk,
  input  logic              iRstN,
  input  logic              iEn,
  input  logic              iClr,
  input  logic              iValid,
  input  logic [DATA_W-1:0] iA,
  input  logic [DATA_W-1:0] iBW,
  input  logic [DATA_W-1:0] iMod,
  output logic              oValid,
  output logic [DATA_W-1:0] oSum,
  output logic [DATA_W-1:0] oDiff
);

  logic [MUL_LAT-1:0][DATA_W-1:0] r_dA;
  logic [MUL_LAT-1:0]             r_dValid;
  logic                           r_valid;
  logic [DATA_W-1:0]              r_sum;
  logic [DATA_W-1:0]              r_diff;
  logic [DATA_W-1:0]              w_sum;
  logic [DATA_W-1:0]              w_diff;

  mod_add_sub_32b #(
    .DATA_W (DATA_W)
  ) u_mod_add_sub (
    .iA    (r_dA[MUL_LAT-1]),
    .iBW   (iBW),
    .iMod  (iMod),
    .oSum  (w_sum),
    .oDiff (w_diff)
  );

  // Data stages shift regardless of valid; only the valid bits qualify them.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_dA     <= '0;
      r_dValid <= '0;
      r_valid  <= 1'b0;
      r_sum    <= '0;
      r_diff   <= '0;
    end else if (iClr) begin
      r_dA     <= '0;
      r_dValid <= '0;
      r_valid  <= 1'b0;
      r_sum    <= '0;
      r_diff   <= '0;
    end else if (iEn) begin
      r_dA[0]     <= iA;
      r_dValid[0] <= iValid;
      for (int unsigned k = 1; k < MUL_LAT; k++) begin
        r_dA[k]     <= r_dA[k-1];
        r_dValid[k] <= r_dValid[k-1];
      end
      r_valid <= r_dValid[MUL_LAT-1];
      r_sum   <= w_sum;
      r_diff  <= w_diff;
    end
  end

  assign oValid = r_valid;
  assign oSum   = r_sum;
  assign oDiff  = r_diff;

endmodule

// File: tb/tb_ntt_butterfly_ct_32b.sv
// Directed bench for ntt_butterfly_ct_32b. The upstream multiplier is stood in for by a
// small BW delay line that advances, stalls and flushes exactly like the DUT's A pipe.
// Build with NTT_BUTTERFLY_DIV2_EN defined to exercise the halving variant.
module tb_ntt_butterfly_ct_32b;

  localparam int unsigned L = 10;
  localparam logic [31:0] Q = 32'hFFFF_FFFB;

`ifdef NTT_BUTTERFLY_DIV2_EN
  localparam bit Div2En = 1'b1;
`else
  localparam bit Div2En = 1'b0;
`endif

  logic        iClk;
  logic        iRstN;
  logic        iEn;
  logic        iClr;
  logic        iValid;
  logic [31:0] iA;
  logic [31:0] iBW;
  logic [31:0] iMod;
  logic        oValid;
  logic [31:0] oSum;
  logic [31:0] oDiff;

  logic [31:0] bw_pipe [L];
  int tests;
  int fails;

  ntt_butterfly_ct_32b #(
    .DATA_W  (32),
    .MUL_LAT (L)
  ) dut (
    .iClk   (iClk),
    .iRstN  (iRstN),
    .iEn    (iEn),
    .iClr   (iClr),
    .iValid (iValid),
    .iA     (iA),
    .iBW    (iBW),
    .iMod   (iMod),
    .oValid (oValid),
    .oSum   (oSum),
    .oDiff  (oDiff)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  function automatic logic [31:0] half_mod(input logic [31:0] x, input logic [31:0] q);
    longint t;
    t = longint'(x);
    if (x[0]) t = t + longint'(q);
    return 32'(t / 2);
  endfunction

  function automatic logic [31:0] adj(input logic [31:0] x, input logic [31:0] q);
    return Div2En ? half_mod(x, q) : x;
  endfunction

  function automatic logic [31:0] gold_sum(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] q);
    return adj(32'((longint'(a) + longint'(b)) % longint'(q)), q);
  endfunction

  function automatic logic [31:0] gold_diff(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] q);
    return adj(32'((longint'(a) + longint'(q) - longint'(b)) % longint'(q)), q);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: inputs applied now, BW for the item at the last A stage presented alongside.
  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] bw,
                       input logic en, input logic clr);
    iValid = v;
    iA     = a;
    iEn    = en;
    iClr   = clr;
    iBW    = bw_pipe[L-1];
    @(posedge iClk);
    if (clr) begin
      for (int k = 0; k < L; k++) bw_pipe[k] = '0;
    end else if (en) begin
      for (int k = L - 1; k > 0; k--) bw_pipe[k] = bw_pipe[k-1];
      bw_pipe[0] = bw;
    end
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
  endtask

  task automatic do_reset(input logic [31:0] q);
    iRstN  = 1'b0;
    iEn    = 1'b0;
    iClr   = 1'b0;
    iValid = 1'b0;
    iA     = '0;
    iBW    = '0;
    iMod   = q;
    for (int k = 0; k < L; k++) bw_pipe[k] = '0;
    repeat (2) @(posedge iClk);
    #1;
    iRstN = 1'b1;
  endtask

  task automatic issue_and_wait(input string tag, input logic [31:0] a, input logic [31:0] bw,
                                input logic [31:0] es, input logic [31:0] ed);
    drive(1'b1, a, bw, 1'b1, 1'b0);
    for (int i = 1; i < L; i++) idle();
    check({tag, "_early"}, 32'(oValid), 32'd0);
    idle();
    check({tag, "_valid"}, 32'(oValid), 32'd1);
    check({tag, "_sum"}, oSum, es);
    check({tag, "_diff"}, oDiff, ed);
  endtask

  initial begin
    int e;
    logic [31:0] ea [20];
    logic [31:0] eb [20];
    tests = 0;
    fails = 0;

    // Reset state
    do_reset(Q);
    check("rst_valid", 32'(oValid), 32'd0);
    check("rst_sum", oSum, 32'd0);
    check("rst_diff", oDiff, 32'd0);

    // Directed vectors and boundaries (hand-computed plain results, then halving if enabled)
    issue_and_wait("basic", 32'd5, 32'd3, adj(32'd8, Q), adj(32'd2, Q));
    issue_and_wait("wrap_sum", 32'd1, 32'hFFFF_FFFA, adj(32'd0, Q), adj(32'd2, Q));
    issue_and_wait("max_max", 32'hFFFF_FFFA, 32'hFFFF_FFFA, adj(32'hFFFF_FFF9, Q), adj(32'd0, Q));
    issue_and_wait("zero", 32'd0, 32'd0, 32'd0, 32'd0);
    issue_and_wait("borrow", 32'd0, 32'd1, adj(32'd1, Q), adj(32'hFFFF_FFFA, Q));

    // Small modulus: plain 5/3, halved (5+17)>>1=11 and (3+17)>>1=10
    do_reset(32'd17);
    issue_and_wait("q17", 32'd4, 32'd1, Div2En ? 32'd11 : 32'd5, Div2En ? 32'd10 : 32'd3);

    // Back-to-back 20 issues
    do_reset(Q);
    for (int i = 0; i < 20; i++) begin
      ea[i] = 32'((longint'(i) * 64'h9E37_79B9 + 64'd11) % longint'(Q));
      eb[i] = 32'((longint'(i) * 64'h7F4A_7C15 + 64'd7) % longint'(Q));
    end
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc < 20) drive(1'b1, ea[cyc], eb[cyc], 1'b1, 1'b0);
      else idle();
      e = (cyc >= L && cyc < L + 20) ? cyc - L : -1;
      check("b2b_valid", 32'(oValid), (e >= 0) ? 32'd1 : 32'd0);
      if (e >= 0) begin
        check("b2b_sum", oSum, gold_sum(ea[e], eb[e], Q));
        check("b2b_diff", oDiff, gold_diff(ea[e], eb[e], Q));
      end
    end

    // Stall for 5 cycles while outputs are live: item1 held, items 2..5 see latency 16
    do_reset(Q);
    for (int cyc = 0; cyc < 24; cyc++) begin
      if (cyc < 6) drive(1'b1, 32'(100 + cyc), 32'(3 * cyc), 1'b1, 1'b0);
      else if (cyc >= 12 && cyc <= 16) drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      else idle();
      if (cyc == 10) e = 0;
      else if (cyc >= 11 && cyc <= 16) e = 1;
      else if (cyc >= 17 && cyc <= 20) e = cyc - 15;
      else e = -1;
      check("stall_valid", 32'(oValid), (e >= 0) ? 32'd1 : 32'd0);
      if (e >= 0) begin
        check("stall_sum", oSum, adj(32'(100 + 4 * e), Q));
        check("stall_diff", oDiff, adj(32'(100 - 2 * e), Q));
      end
    end

    // Flush with 6 items in flight (iEn also high: iClr must win)
    do_reset(Q);
    for (int cyc = 0; cyc < 21; cyc++) begin
      if (cyc < 6) drive(1'b1, 32'(cyc + 1), 32'd1, 1'b1, 1'b0);
      else if (cyc == 6) drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
      else idle();
      check("clr_valid", 32'(oValid), 32'd0);
    end
    check("clr_sum", oSum, 32'd0);
    issue_and_wait("post_clr", 32'd7, 32'd2, adj(32'd9, Q), adj(32'd5, Q));

    // Asynchronous reset mid-stream
    do_reset(Q);
    for (int cyc = 0; cyc < 13; cyc++) drive(1'b1, 32'(cyc + 20), 32'd4, 1'b1, 1'b0);
    check("pre_rst_valid", 32'(oValid), 32'd1);
    check("pre_rst_sum", oSum, adj(32'd26, Q));
    #2;
    iRstN = 1'b0;
    for (int k = 0; k < L; k++) bw_pipe[k] = '0;
    #1;
    check("arst_valid", 32'(oValid), 32'd0);
    check("arst_sum", oSum, 32'd0);
    check("arst_diff", oDiff, 32'd0);
    @(posedge iClk);
    #1;
    iRstN = 1'b1;
    for (int cyc = 0; cyc < 15; cyc++) begin
      idle();
      check("post_rst_valid", 32'(oValid), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
